tt_sweep_checker: RTL and testbench

Parametrised, synthesisable exhaustive truth-table sweeper for combinational lab blocks.
- Drives every input pattern 0 .. 2^IN_W-1 into a DUT and holds each pattern for DWELL cycles.
- Samples the DUT response once per pattern and folds it into a 16-bit signature.
- Replaces hand-written per-pattern stimulus lists; sits between a top-level lab harness and any N-input/M-output combinational DUT.

---
 rtl/tt_sweep_pkg.sv | 13 +
 rtl/tt_sweep_checker_sig_misr16.sv | 21 ++
 rtl/tt_sweep_checker.sv | 121 ++++++++++++
 tb/tb_tt_sweep_checker.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

endpackage

// File: rtl/tt_sweep_checker_sig_misr16.sv
// 16-bit CRC-style signature register: shift, conditionally fold in the polynomial, xor in the data word.
module sig_misr16
  import tt_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input pattern into a combinational DUT and signs its responses.
// Optional per-pattern compare against an expected response is enabled with the TT_SWEEP_CMP_EN macro.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 2,
  parameter int DWELL  = 20,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] resp,
`ifdef TT_SWEEP_CMP_EN
  input  logic [OUT_W-1:0] expected,
  output logic [IN_W:0]    err_cnt,
  output logic [IN_W-1:0]  first_err_idx,
  output logic             first_err_valid,
`endif
  output logic [IN_W-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             sample_valid,
  output logic [OUT_W-1:0] sample_data,
  output logic [SIG_W-1:0] signature
);

  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
  localparam logic [IN_W-1:0]  STIM_LAST  = '1;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] dwell_cnt;
  logic             sweep_start;
  logic             sample_hit;
  logic             pattern_end;
  logic             last_pattern;

  always_comb begin
    next_state   = state;
    sweep_start  = 1'b0;
    sample_hit   = (state == RUN) && (dwell_cnt == CNT_SETTLE);
    pattern_end  = (state == RUN) && (dwell_cnt == CNT_LAST);
    last_pattern = (stim == STIM_LAST);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          sweep_start = 1'b1;
          next_state  = RUN;
        end
      end
      RUN: begin
        if (pattern_end && last_pattern) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The all-ones check happens before the increment, so stim never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      stim         <= '0;
      dwell_cnt    <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      sample_valid <= sample_hit;
      if (sample_hit) sample_data <= resp;
      if (sweep_start) begin
        stim      <= '0;
        dwell_cnt <= '0;
      end else if (state == RUN) begin
        if (pattern_end) begin
          dwell_cnt <= '0;
          if (!last_pattern) stim <= stim + 1'b1;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  sig_misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (sweep_start),
    .en  (sample_hit),
    .din (SIG_W'(resp)),
    .sig (signature)
  );

`ifdef TT_SWEEP_CMP_EN
  localparam logic [IN_W:0] ERR_MAX = {1'b1, {IN_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst || sweep_start) begin
      err_cnt         <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (sample_hit && (resp != expected)) begin
      if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
      if (!first_err_valid) begin
        first_err_idx   <= stim;
        first_err_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: three instances (small, default, late-sample) share clk and rst.
// Compare-feature checks are built only when TT_SWEEP_CMP_EN is defined.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  logic        start_s = 1'b0;
  logic        resp_s;
  logic [1:0]  stim_s;
  logic        busy_s, done_s, sv_s, sd_s;
  logic [15:0] sig_s;

  logic        start_d = 1'b0;
  logic [1:0]  resp_d;
  logic [3:0]  stim_d;
  logic        busy_d, done_d, sv_d;
  logic [1:0]  sd_d;
  logic [15:0] sig_d;

  logic        start_l = 1'b0;
  logic        resp_l;
  logic [1:0]  stim_l;
  logic        busy_l, done_l, sv_l, sd_l;
  logic [15:0] sig_l;

  assign resp_s = stim_s[0] ^ stim_s[1];
  assign resp_d = {^stim_d, &stim_d};
  assign resp_l = stim_l[0] ^ stim_l[1];

`ifdef TT_SWEEP_CMP_EN
  logic       exp_s, exp_l;
  logic [1:0] exp_d;
  logic [2:0] ecnt_s, ecnt_l;
  logic [4:0] ecnt_d;
  logic [1:0] eidx_s, eidx_l;
  logic [3:0] eidx_d;
  logic       evld_s, evld_d, evld_l;
  assign exp_s = stim_s[0] | stim_s[1];
  assign exp_d = resp_d;
  assign exp_l = resp_l;
`endif

  tt_sweep_checker #(.IN_W(2), .OUT_W(1), .DWELL(3), .SETTLE(1)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .resp(resp_s),
`ifdef TT_SWEEP_CMP_EN
    .expected(exp_s), .err_cnt(ecnt_s), .first_err_idx(eidx_s), .first_err_valid(evld_s),
`endif
    .stim(stim_s), .busy(busy_s), .done(done_s), .sample_valid(sv_s),
    .sample_data(sd_s), .signature(sig_s)
  );

  tt_sweep_checker u_dflt (
    .clk(clk), .rst(rst), .start(start_d), .resp(resp_d),
`ifdef TT_SWEEP_CMP_EN
    .expected(exp_d), .err_cnt(ecnt_d), .first_err_idx(eidx_d), .first_err_valid(evld_d),
`endif
    .stim(stim_d), .busy(busy_d), .done(done_d), .sample_valid(sv_d),
    .sample_data(sd_d), .signature(sig_d)
  );

  tt_sweep_checker #(.IN_W(2), .OUT_W(1), .DWELL(3), .SETTLE(2)) u_late (
    .clk(clk), .rst(rst), .start(start_l), .resp(resp_l),
`ifdef TT_SWEEP_CMP_EN
    .expected(exp_l), .err_cnt(ecnt_l), .first_err_idx(eidx_l), .first_err_valid(evld_l),
`endif
    .stim(stim_l), .busy(busy_l), .done(done_l), .sample_valid(sv_l),
    .sample_data(sd_l), .signature(sig_l)
  );

  logic [1:0] cap_d [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one default-parameter sweep and records what was observed; comparisons live in the callers.
  task automatic sweep_default(output int done_k, output int pulses, output logic [15:0] sig_at_done,
                               output logic [3:0] stim_at_done);
    done_k = 0;
    pulses = 0;
    sig_at_done = '0;
    stim_at_done = '0;
    start_d = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      start_d = 1'b0;
      if (sv_d) begin
        if (pulses < 16) cap_d[pulses] = sd_d;
        pulses++;
      end
      if (done_d) begin
        done_k = k;
        sig_at_done = sig_d;
        stim_at_done = stim_d;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({stim_d, busy_d, done_d, sv_d, sd_d, sig_d} !== 25'h0) begin
      bad++;
      $display("FAIL reset_dflt got=%h want=0", {stim_d, busy_d, done_d, sv_d, sd_d, sig_d});
    end
    total++;
    if ({stim_s, busy_s, done_s, sv_s, sd_s, sig_s} !== 22'h0) begin
      bad++;
      $display("FAIL reset_small got=%h want=0", {stim_s, busy_s, done_s, sv_s, sd_s, sig_s});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_truth_table();
    logic [3:0] data_tbl;
    int p;
    data_tbl = 4'b0110;
    start_s = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      start_s = 1'b0;
      total++;
      if (stim_s !== ((k <= 12) ? 2'((k - 1) / 3) : 2'd3)) begin
        bad++;
        $display("FAIL tt_stim k=%0d got=%0d want=%0d", k, stim_s, (k <= 12) ? (k - 1) / 3 : 3);
      end
      total++;
      if (sv_s !== ((k % 3) == 0)) begin
        bad++;
        $display("FAIL tt_valid k=%0d got=%b want=%b", k, sv_s, (k % 3) == 0);
      end
      if ((k % 3) == 0) begin
        p = k / 3 - 1;
        total++;
        if (sd_s !== data_tbl[p]) begin
          bad++;
          $display("FAIL tt_data pattern=%0d got=%b want=%b", p, sd_s, data_tbl[p]);
        end
      end
      total++;
      if ({busy_s, done_s} !== ((k < 13) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL tt_busy_done k=%0d got=%b want=%b", k, {busy_s, done_s}, (k < 13) ? 2'b10 : 2'b01);
      end
    end
    total++;
    if (sig_s !== 16'h0006) begin
      bad++;
      $display("FAIL tt_signature got=%h want=0006", sig_s);
    end
  endtask

  task automatic test_default_sweep();
    int done_k, pulses;
    logic [15:0] sg;
    logic [3:0] st;
    logic [3:0] pv;
    sweep_default(done_k, pulses, sg, st);
    total++;
    if (done_k != 321) begin
      bad++;
      $display("FAIL dflt_done_latency got=%0d want=321", done_k);
    end
    total++;
    if (pulses != 16) begin
      bad++;
      $display("FAIL dflt_pulses got=%0d want=16", pulses);
    end
    total++;
    if (st !== 4'hF) begin
      bad++;
      $display("FAIL dflt_stim_done got=%h want=f", st);
    end
    total++;
    if (sg !== 16'hD32D) begin
      bad++;
      $display("FAIL dflt_signature got=%h want=d32d", sg);
    end
    for (int p = 0; p < 16 && p < pulses; p++) begin
      pv = 4'(p);
      total++;
      if (cap_d[p] !== {^pv, &pv}) begin
        bad++;
        $display("FAIL dflt_data pattern=%0d got=%b want=%b", p, cap_d[p], {^pv, &pv});
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_k, pulses;
    logic [15:0] sg;
    logic [3:0] st;
    start_d = 1'b1;
    for (int k = 1; k <= 104; k++) begin
      tick();
      start_d = 1'b0;
    end
    total++;
    if ({busy_d, stim_d} !== 5'h15) begin
      bad++;
      $display("FAIL mid_pattern got=%h want=15", {busy_d, stim_d});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({stim_d, busy_d, done_d, sv_d, sd_d, sig_d} !== 25'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h want=0", {stim_d, busy_d, done_d, sv_d, sd_d, sig_d});
    end
    tick();
    total++;
    if ({busy_d, stim_d} !== 5'h00) begin
      bad++;
      $display("FAIL mid_stays_idle got=%h want=00", {busy_d, stim_d});
    end
    sweep_default(done_k, pulses, sg, st);
    total++;
    if (sg !== 16'hD32D || done_k != 321) begin
      bad++;
      $display("FAIL mid_rerun got=%h/%0d want=d32d/321", sg, done_k);
    end
  endtask

  task automatic test_start_held();
    start_s = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 5) begin
        total++;
        if ({busy_s, stim_s} !== 3'b101) begin
          bad++;
          $display("FAIL held_ignored got=%b want=101", {busy_s, stim_s});
        end
      end
      if (k == 13) begin
        total++;
        if ({done_s, busy_s, sig_s} !== {2'b10, 16'h0006}) begin
          bad++;
          $display("FAIL held_done got=%h want=20006", {done_s, busy_s, sig_s});
        end
      end
      if (k == 14) begin
        total++;
        if ({done_s, busy_s, stim_s, sig_s} !== {2'b01, 2'b00, 16'h0000}) begin
          bad++;
          $display("FAIL held_restart got=%h want=40000", {done_s, busy_s, stim_s, sig_s});
        end
      end
    end
    start_s = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_late_settle();
    start_l = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      start_l = 1'b0;
      total++;
      if (sv_l !== ((k % 3) == 1 && k > 1)) begin
        bad++;
        $display("FAIL late_valid k=%0d got=%b want=%b", k, sv_l, (k % 3) == 1 && k > 1);
      end
    end
    total++;
    if ({done_l, sv_l, sd_l, stim_l, sig_l} !== {3'b110, 2'b11, 16'h0006}) begin
      bad++;
      $display("FAIL late_final got=%h want=1b0006", {done_l, sv_l, sd_l, stim_l, sig_l});
    end
  endtask

`ifdef TT_SWEEP_CMP_EN
  task automatic test_compare();
    start_s = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      start_s = 1'b0;
      if (k == 1) begin
        total++;
        if ({ecnt_s, evld_s} !== 4'b0000) begin
          bad++;
          $display("FAIL cmp_clear got=%b want=0000", {ecnt_s, evld_s});
        end
      end
    end
    total++;
    if ({done_s, ecnt_s, eidx_s, evld_s} !== {1'b1, 3'd1, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL cmp_result got=%b want=1001111", {done_s, ecnt_s, eidx_s, evld_s});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_default_sweep();
    test_reset_mid_sweep();
    test_start_held();
    test_late_settle();
`ifdef TT_SWEEP_CMP_EN
    test_compare();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
